// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, data width and default clock/baud constants.
// UART_TX_PARITY_EN adds the PARITY state and widens the state encoding to 3 bits.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS     = 8;
    localparam int unsigned DEFAULT_CLOCK_FREQ = 125_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE  = 115_200;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StStop   = 3'd3,
        StParity = 3'd4
    } tx_state_e;
`else
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-period counter: counts 0..SymbolEdgeTime-1 and flags the last cycle of each period.
// Synchronous clear and synchronous active-low reset; shared with the receiver.
module uart_baud_tick #(
    parameter int unsigned SymbolEdgeTime = 2,
    parameter int unsigned CounterWidth   = $clog2(SymbolEdgeTime)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [CounterWidth-1:0] LastCount = CounterWidth'(SymbolEdgeTime - 1);

    logic [CounterWidth-1:0] count_q, count_d;

    assign tick_o = (count_q == LastCount);

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear_i || tick_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: accepts a byte over ready/valid and sends an 8N1 frame, LSB first.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
    parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [UART_DATA_BITS-1:0] data_in,
    input  logic                      data_in_valid,
    output logic                      data_in_ready,
    output logic                      serial_out
);

    localparam int unsigned SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
    localparam int unsigned BitIdxWidth         = $clog2(UART_DATA_BITS);
    localparam logic [BitIdxWidth-1:0] LastBit  = BitIdxWidth'(UART_DATA_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [BitIdxWidth-1:0]    bit_idx_q, bit_idx_d;
    logic                      serial_q, serial_d;
    logic                      handshake;
    logic                      baud_clear;
    logic                      baud_tick;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    assign data_in_ready = (state_q == StIdle) && rst_n;
    assign handshake     = data_in_valid && data_in_ready;
    assign serial_out    = serial_q;
    // Holding the counter clear while idle aligns the first period with the accept edge.
    assign baud_clear    = (state_q == StIdle);

    uart_baud_tick #(
        .SymbolEdgeTime (SYMBOL_EDGE_TIME),
        .CounterWidth   (CLOCK_COUNTER_WIDTH)
    ) u_baud_tick (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (baud_clear),
        .tick_o  (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (handshake) begin
                    shift_d   = data_in;
                    bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^data_in;
`endif
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (baud_tick) state_d = StData;
            end
            StData: begin
                if (baud_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_tick) state_d = StStop;
            end
`endif
            StStop: begin
                if (baud_tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Line level is decoded from the next state so serial_out is a clean register.
        serial_d = 1'b1;
        case (state_d)
            StStart:  serial_d = 1'b0;
            StData:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: serial_d = parity_d;
`endif
            default:  serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            serial_q  <= serial_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a per-cycle scoreboard of expected line levels is filled on each
// accepted byte and drained every cycle; directed steps cover reset, back-to-back, busy, abort.
module tb_uart_transmitter;

    localparam int unsigned T = 10;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME = 11 * T;
`else
    localparam int unsigned FRAME = 10 * T;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cycle   = 0;

    logic sb[$];
    logic mon_line;
    logic mon_ready;

    uart_transmitter #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One queue entry per clock cycle of the frame.
    function automatic void push_frame(input logic [7:0] b);
        for (int i = 0; i < int'(T); i++) sb.push_back(1'b0);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < int'(T); i++) sb.push_back(b[k]);
        end
`ifdef UART_TX_PARITY_EN
        for (int i = 0; i < int'(T); i++) sb.push_back(^b);
`endif
        for (int i = 0; i < int'(T); i++) sb.push_back(1'b1);
    endfunction

    // Inputs only move #1 after a rising edge, so the falling edge sees what the next edge samples.
    always @(negedge clk) begin
        mon_ready = rst_n && (sb.size() == 0);
        mon_line  = (sb.size() != 0) ? sb.pop_front() : 1'b1;
        check_bit("serial_out", serial_out, mon_line);
        check_bit("data_in_ready", data_in_ready, mon_ready);
        if (!rst_n) sb.delete();
        else if (mon_ready && data_in_valid) push_frame(data_in);
    end

    task automatic send(input logic [7:0] b, input bit hold, output int hs_cycle);
        bit done;
        done = 1'b0;
        data_in       = b;
        data_in_valid = 1'b1;
        for (int n = 0; n < 3 * int'(FRAME) && !done; n++) begin
            @(negedge clk);
            if (data_in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        hs_cycle = cycle;
        if (!hold) data_in_valid = 1'b0;
        check_int("handshake_seen", int'(done), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int c1;

        // Reset held for three edges, then a long idle stretch.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(50);

        // Single byte 0xA5.
        send(8'hA5, 1'b0, c0);
        idle(FRAME + 5);

        // Back-to-back with valid held: second accept exactly one cycle after the frame.
        send(8'h00, 1'b1, c0);
        send(8'hFF, 1'b0, c1);
        check_int("b2b_gap", c1 - c0, int'(FRAME) + 1);
        idle(FRAME + 5);

        // Busy ignore: a mid-frame valid pulse with new data must not disturb 0xA5.
        send(8'hA5, 1'b0, c0);
        idle(30);
        data_in       = 8'h3C;
        data_in_valid = 1'b1;
        idle(1);
        data_in_valid = 1'b0;
        idle(FRAME);

        // Reset during data bit 3, then a clean 0x55 frame.
        send(8'hA5, 1'b0, c0);
        idle(44);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(3);
        send(8'h55, 1'b0, c0);
        idle(FRAME + 5);

        // Odd-weight byte (parity bit 1 when enabled).
        send(8'h07, 1'b0, c0);
        idle(FRAME + 5);

        check_int("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
